// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI mode-0 peripheral (spi_slave_cont).
//   DATA_W_DEF / SYNC_STAGES_DEF : default word width and synchronizer depth
//   ST_IDLE / ST_LOAD / ST_SHIFT : transfer FSM state encoding
//   IDLE_MISO                    : MISO level while deselected
//   UNDERRUN_WORD                : word sent when the reply buffer is empty
//   cnt_width()                  : bit-counter width for a given word size
package spi_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 2'd1;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd2;

  localparam logic IDLE_MISO = 1'b1;
  localparam logic [DATA_W_DEF-1:0] UNDERRUN_WORD = '1;

  // Counter width able to hold 0 .. w-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous input with
// registered single-cycle rise/fall pulses derived from the last two
// synchronized samples.
//   clk_i   in  : sampling clock
//   rst_ni  in  : asynchronous active-low reset (chain resets to RST_VAL)
//   d_i     in  : asynchronous input
//   rise_o  out : 1-cycle pulse on a 0->1 transition of the synchronized level
//   fall_o  out : 1-cycle pulse on a 1->0 transition of the synchronized level
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, one-sample history and edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= level;
      rise_q <= level & ~prev_q;
      fall_q <= ~level & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_cont.sv
// spi_slave_cont: SPI mode-0 (CPOL=0, CPHA=0, MSB first) peripheral that
// oversamples SCLK/CS_N/MOSI in the CLK50 domain.
//   CLK50, RST_N        : system clock, asynchronous active-low reset
//   SCLK, CS_N, MOSI    : SPI bus from the master (asynchronous)
//   MISO, MISO_OE       : reply data and its output enable
//   TX_STB/TX_DATA      : load a reply word into the one-deep buffer
//   TX_ACK, TX_READY    : capture pulse, buffer-empty flag
//   RX_STB, RX_DATA     : received-word pulse and held word
// Optional (macro SPI_SLAVE_STATUS_EN): RX_CLR in, sticky RX_OVR / TX_UDR out.
module spi_slave_cont
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              CLK50,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic              TX_STB,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_ACK,
  output logic              TX_READY,
  output logic              RX_STB,
`ifdef SPI_SLAVE_STATUS_EN
  input  logic              RX_CLR,
  output logic              RX_OVR,
  output logic              TX_UDR,
`endif
  output logic [DATA_W-1:0] RX_DATA
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);
  localparam logic [DATA_W-1:0] UNDERRUN = {DATA_W{UNDERRUN_WORD[0]}};

  // Synchronized bus events.
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i  (CLK50),
    .rst_ni (RST_N),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i  (CLK50),
    .rst_ni (RST_N),
    .d_i    (CS_N),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Plain synchronizer for MOSI; data needs no edge detection.
  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Transfer state and datapath registers.
  logic [STATE_W-1:0] state_q,    state_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  rx_data_q,  rx_data_d;
  logic               rx_stb_q,   rx_stb_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  buf_q,      buf_d;
  logic               tx_ready_q, tx_ready_d;
  logic               tx_ack_q,   tx_ack_d;
  logic               miso_oe_q,  miso_oe_d;
  logic               miso_q,     miso_d;
  logic               reload;
  logic [DATA_W-1:0]  rx_word;

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_stb_q   <= 1'b0;
      tx_shift_q <= UNDERRUN;
      buf_q      <= '0;
      tx_ready_q <= 1'b1;
      tx_ack_q   <= 1'b0;
      miso_oe_q  <= 1'b0;
      miso_q     <= IDLE_MISO;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_stb_q   <= rx_stb_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      tx_ready_q <= tx_ready_d;
      tx_ack_q   <= tx_ack_d;
      miso_oe_q  <= miso_oe_d;
      miso_q     <= miso_d;
    end
  end

  // Next-state, shift and buffer logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_stb_d   = 1'b0;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    tx_ready_d = tx_ready_q;
    tx_ack_d   = 1'b0;
    miso_oe_d  = miso_oe_q;
    reload     = 1'b0;
    rx_word    = {rx_shift_q[DATA_W-2:0], mosi_s};

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          miso_oe_d = 1'b1;
          reload    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // Deselect aborts any partial word.
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_oe_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              rx_data_d = rx_word;
              rx_stb_d  = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // Counter at 0 on a falling edge marks the word boundary.
          if (sclk_fall) begin
            if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
            else                 reload     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reload consumes the old buffer before a same-cycle TX_STB refills it.
    if (reload) begin
      tx_shift_d = tx_ready_q ? UNDERRUN : buf_q;
      tx_ready_d = 1'b1;
    end
    if (TX_STB && (tx_ready_q || reload)) begin
      buf_d      = TX_DATA;
      tx_ready_d = 1'b0;
      tx_ack_d   = 1'b1;
    end

    miso_d = miso_oe_d ? tx_shift_d[DATA_W-1] : IDLE_MISO;
  end

  assign MISO     = miso_q;
  assign MISO_OE  = miso_oe_q;
  assign TX_ACK   = tx_ack_q;
  assign TX_READY = tx_ready_q;
  assign RX_STB   = rx_stb_q;
  assign RX_DATA  = rx_data_q;

`ifdef SPI_SLAVE_STATUS_EN
  // Sticky overrun/underrun flags; RX_CLR also acknowledges the pending word.
  logic rx_pend_q, rx_pend_d;
  logic rx_ovr_q,  rx_ovr_d;
  logic tx_udr_q,  tx_udr_d;

  always_comb begin
    rx_pend_d = rx_stb_d | (rx_pend_q & ~RX_CLR);
    rx_ovr_d  = (rx_ovr_q & ~RX_CLR) | (rx_stb_d & rx_pend_q & ~RX_CLR);
    tx_udr_d  = (tx_udr_q & ~RX_CLR) | (reload & tx_ready_q);
  end

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      rx_pend_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      tx_udr_q  <= 1'b0;
    end else begin
      rx_pend_q <= rx_pend_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_udr_q  <= tx_udr_d;
    end
  end

  assign RX_OVR = rx_ovr_q;
  assign TX_UDR = tx_udr_q;
`endif

endmodule

// File: tb/tb_spi_slave_cont.sv
// Directed bench for spi_slave_cont: acts as an SPI mode-0 master with SCLK at
// 1/16 of CLK50 and checks received words, MISO replies and the TX handshake.
module tb_spi_slave_cont;

  logic       CLK50 = 1'b0;
  logic       RST_N;
  logic       SCLK;
  logic       CS_N;
  logic       MOSI;
  logic       MISO;
  logic       MISO_OE;
  logic       TX_STB;
  logic [7:0] TX_DATA;
  logic       TX_ACK;
  logic       TX_READY;
  logic       RX_STB;
  logic [7:0] RX_DATA;
`ifdef SPI_SLAVE_STATUS_EN
  logic       RX_CLR;
  logic       RX_OVR;
  logic       TX_UDR;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int rx_stb_cnt = 0;
  int tx_ack_cnt = 0;

  spi_slave_cont dut (
    .CLK50    (CLK50),
    .RST_N    (RST_N),
    .SCLK     (SCLK),
    .CS_N     (CS_N),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_OE  (MISO_OE),
    .TX_STB   (TX_STB),
    .TX_DATA  (TX_DATA),
    .TX_ACK   (TX_ACK),
    .TX_READY (TX_READY),
    .RX_STB   (RX_STB),
`ifdef SPI_SLAVE_STATUS_EN
    .RX_CLR   (RX_CLR),
    .RX_OVR   (RX_OVR),
    .TX_UDR   (TX_UDR),
`endif
    .RX_DATA  (RX_DATA)
  );

  always #10 CLK50 = ~CLK50;

  // Pulse counters sampled mid-cycle; a one-cycle pulse counts exactly once.
  always @(negedge CLK50) begin
    if (RX_STB === 1'b1) rx_stb_cnt = rx_stb_cnt + 1;
    if (TX_ACK === 1'b1) tx_ack_cnt = tx_ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK50);
    #1;
  endtask

  task automatic tx_load(input logic [7:0] d);
    TX_DATA = d;
    TX_STB  = 1'b1;
    cyc(1);
    TX_STB  = 1'b0;
  endtask

  task automatic cs_low();
    CS_N = 1'b0;
    cyc(8);
  endtask

  task automatic cs_high();
    CS_N = 1'b1;
    cyc(8);
  endtask

  // Clock out the top n bits of b; MISO is captured just before each rising edge.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = b[7-i];
      cyc(8);
      m[7-i] = MISO;
      SCLK = 1'b1;
      cyc(8);
      SCLK = 1'b0;
    end
    cyc(8);
  endtask

  initial begin
    logic [7:0] m1;
    logic [7:0] m2;
    int stb0;
    int ack0;

    RST_N = 1'b0; SCLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
    TX_STB = 1'b0; TX_DATA = 8'h00;
`ifdef SPI_SLAVE_STATUS_EN
    RX_CLR = 1'b0;
`endif
    cyc(3);
    check("rst_miso",     32'(MISO),     32'h1);
    check("rst_miso_oe",  32'(MISO_OE),  32'h0);
    check("rst_tx_ack",   32'(TX_ACK),   32'h0);
    check("rst_tx_ready", 32'(TX_READY), 32'h1);
    check("rst_rx_stb",   32'(RX_STB),   32'h0);
    check("rst_rx_data",  32'(RX_DATA),  32'h0);
    RST_N = 1'b1;
    cyc(3);

    // 1: reply 0xA5 while receiving 0x3C
    ack0 = tx_ack_cnt; stb0 = rx_stb_cnt;
    tx_load(8'hA5);
    check("t1_ack_hi",   32'(TX_ACK),   32'h1);
    check("t1_ready_lo", 32'(TX_READY), 32'h0);
    cyc(1);
    check("t1_ack_lo",   32'(TX_ACK),   32'h0);
    cs_low();
    check("t1_oe_sel",   32'(MISO_OE),  32'h1);
    spi_bits(8'h3C, 8, m1);
    cs_high();
    check("t1_miso",     32'(m1),       32'hA5);
    check("t1_rx_data",  32'(RX_DATA),  32'h3C);
    check("t1_stb_cnt",  32'(rx_stb_cnt - stb0), 32'd1);
    check("t1_ack_cnt",  32'(tx_ack_cnt - ack0), 32'd1);
    check("t1_oe_desel", 32'(MISO_OE),  32'h0);
    check("t1_miso_idl", 32'(MISO),     32'h1);

    // 2: no reply loaded -> underrun word
    check("t2_ready", 32'(TX_READY), 32'h1);
    stb0 = rx_stb_cnt;
    cs_low();
    spi_bits(8'h81, 8, m1);
    cs_high();
    check("t2_miso",    32'(m1),      32'hFF);
    check("t2_rx_data", 32'(RX_DATA), 32'h81);
    check("t2_stb_cnt", 32'(rx_stb_cnt - stb0), 32'd1);
`ifdef SPI_SLAVE_STATUS_EN
    check("t2_tx_udr",  32'(TX_UDR), 32'h1);
    check("t2_rx_ovr",  32'(RX_OVR), 32'h1);
    RX_CLR = 1'b1;
    cyc(1);
    RX_CLR = 1'b0;
    cyc(1);
    check("t2_udr_clr", 32'(TX_UDR), 32'h0);
    check("t2_ovr_clr", 32'(RX_OVR), 32'h0);
`endif

    // 3: two words with CS_N held low; second reply loaded during the first word
    stb0 = rx_stb_cnt;
    tx_load(8'h11);
    cs_low();
    check("t3_ready_after_load", 32'(TX_READY), 32'h1);
    tx_load(8'h22);
    spi_bits(8'hC3, 8, m1);
    check("t3_rx_data1", 32'(RX_DATA), 32'hC3);
    spi_bits(8'h96, 8, m2);
    cs_high();
    check("t3_miso1",    32'(m1),      32'h11);
    check("t3_miso2",    32'(m2),      32'h22);
    check("t3_rx_data2", 32'(RX_DATA), 32'h96);
    check("t3_stb_cnt",  32'(rx_stb_cnt - stb0), 32'd2);

    // 4: aborted word, then a clean one
    stb0 = rx_stb_cnt;
    cs_low();
    spi_bits(8'hFF, 5, m1);
    cs_high();
    check("t4_stb_none",  32'(rx_stb_cnt - stb0), 32'd0);
    check("t4_rx_hold",   32'(RX_DATA), 32'h96);
    check("t4_oe_off",    32'(MISO_OE), 32'h0);
    check("t4_miso_idle", 32'(MISO),    32'h1);
    cs_low();
    spi_bits(8'h5A, 8, m1);
    cs_high();
    check("t4_rx_data",  32'(RX_DATA), 32'h5A);
    check("t4_stb_cnt",  32'(rx_stb_cnt - stb0), 32'd1);

    // 5: second TX_STB while the buffer is full is dropped
    ack0 = tx_ack_cnt;
    tx_load(8'h77);
    cyc(1);
    tx_load(8'h99);
    cyc(2);
    check("t5_ack_cnt", 32'(tx_ack_cnt - ack0), 32'd1);
    check("t5_ready",   32'(TX_READY), 32'h0);
    cs_low();
    spi_bits(8'hA0, 8, m1);
    cs_high();
    check("t5_miso",    32'(m1),      32'h77);
    check("t5_rx_data", 32'(RX_DATA), 32'hA0);

    // 6: reset in the middle of a word
    cs_low();
    tx_load(8'hC5);
    cyc(1);
    check("t6_ready_pre", 32'(TX_READY), 32'h0);
    spi_bits(8'hFF, 4, m1);
    SCLK = 1'b1;
    cyc(2);
    RST_N = 1'b0;
    #2;
    check("t6_miso",     32'(MISO),     32'h1);
    check("t6_miso_oe",  32'(MISO_OE),  32'h0);
    check("t6_tx_ack",   32'(TX_ACK),   32'h0);
    check("t6_tx_ready", 32'(TX_READY), 32'h1);
    check("t6_rx_stb",   32'(RX_STB),   32'h0);
    check("t6_rx_data",  32'(RX_DATA),  32'h0);
    SCLK = 1'b0;
    CS_N = 1'b1;
    cyc(3);
    RST_N = 1'b1;
    cyc(3);
    stb0 = rx_stb_cnt;
    tx_load(8'h6B);
    cs_low();
    spi_bits(8'hF0, 8, m1);
    cs_high();
    check("t6_post_rx",   32'(RX_DATA), 32'hF0);
    check("t6_post_miso", 32'(m1),      32'h6B);
    check("t6_post_stb",  32'(rx_stb_cnt - stb0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
